fp_skew_feeder: RTL and testbench



---
 rtl/fp_skew_feeder.sv | 127 ++++++++++++
 tb/tb_fp_skew_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_skew_feeder.sv
// Skewed operand feeder for the FP16 systolic MAC array; lane i is delayed i cycles.
// Optional accepted-beat counter output beat_cnt_o when FP_SKEW_STATS_EN is defined.
module fp_skew_feeder #(
  parameter int LANES = 4,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic             in_last,
  output logic [LANES*W-1:0] op_o,
  output logic [LANES-1:0] en_o,
  output logic [LANES-1:0] val_o,
  output logic             busy_o,
`ifdef FP_SKEW_STATS_EN
  output logic [15:0]      beat_cnt_o,
`endif
  output logic             done_o
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept;
  logic [LANES-1:0] last_q;

  assign in_ready = (state != DRAIN);
  assign busy_o   = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (!in_last) begin
            state_n = STREAM;
          end else if (LANES == 1) begin
            state_n = IDLE;
          end else begin
            state_n = DRAIN;
            cnt_n   = CW'(LANES - 1);
          end
        end
      end
      DRAIN: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // The last-beat marker travels alongside the deepest lane so done
  // lines up exactly with that lane presenting the final beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else begin
      last_q[0] <= accept && in_last;
      for (int j = 1; j < LANES; j++) last_q[j] <= last_q[j-1];
    end
  end

  assign done_o = last_q[LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] d_q [0:i];
    logic [i:0]   en_q;
    logic [i:0]   val_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int j = 0; j <= i; j++) d_q[j] <= '0;
        en_q  <= '0;
        val_q <= '0;
      end else begin
        if (accept) d_q[0] <= in_data[i*W +: W];
        en_q[0]  <= accept;
        val_q[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          d_q[j]   <= d_q[j-1];
          en_q[j]  <= en_q[j-1];
          val_q[j] <= val_q[j-1];
        end
      end
    end

    assign op_o[i*W +: W] = d_q[i];
    assign en_o[i]        = en_q[i];
    assign val_o[i]       = val_q[i];
  end

`ifdef FP_SKEW_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_o <= '0;
    end else if (accept && beat_cnt_o != 16'hFFFF) begin
      beat_cnt_o <= beat_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_skew_feeder.sv
// Bench for fp_skew_feeder: directed table, hand sequences and random
// traffic checked against a history-based reference model.
module tb_fp_skew_feeder;
  localparam int L  = 4;
  localparam int W  = 16;
  localparam int DW = L * W;
  localparam int R  = 16;

  logic clk = 0;
  logic reset_n = 0;
  logic in_valid = 0;
  logic in_last = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, busy_o, done_o;
  logic [DW-1:0] op_o;
  logic [L-1:0] en_o, val_o;
`ifdef FP_SKEW_STATS_EN
  logic [15:0] beat_cnt_o;
`endif

  fp_skew_feeder #(.LANES(L), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .op_o(op_o), .en_o(en_o), .val_o(val_o),
    .busy_o(busy_o),
`ifdef FP_SKEW_STATS_EN
    .beat_cnt_o(beat_cnt_o),
`endif
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: per-edge history of accepts and of held stage-0 data.
  int k;
  int ready_from;
  bit in_burst;
  int beats;
  bit h_acc [R];
  bit h_last [R];
  logic [DW-1:0] h_hold [R];
  logic [DW-1:0] held;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, k);
    end
  endtask

  task automatic model_clear();
    k = 0; ready_from = 0; in_burst = 0; beats = 0; held = '0;
    for (int i = 0; i < R; i++) begin
      h_acc[i] = 0; h_last[i] = 0; h_hold[i] = '0;
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] eop;
    logic [L-1:0] een;
    int e;
    bit edone;
    e = k - 1;
    eop = '0; een = '0; edone = 0;
    for (int i = 0; i < L; i++) begin
      if (e - i >= 0) begin
        eop[i*W +: W] = h_hold[(e-i) % R][i*W +: W];
        een[i] = h_acc[(e-i) % R];
      end
    end
    if (e - (L-1) >= 0)
      edone = h_acc[(e-L+1) % R] && h_last[(e-L+1) % R];
    chk("op_o", op_o, eop);
    chk("en_o", DW'(en_o), DW'(een));
    chk("val_o", DW'(val_o), DW'(een));
    chk("done_o", DW'(done_o), DW'(edone));
    chk("busy_o", DW'(busy_o), DW'(in_burst || (k < ready_from)));
`ifdef FP_SKEW_STATS_EN
    chk("beat_cnt", DW'(beat_cnt_o), DW'(beats));
`endif
  endtask

  task automatic step(input logic v, input logic l, input logic [DW-1:0] d);
    bit acc;
    in_valid = v; in_last = l; in_data = d;
    acc = v && (k >= ready_from);
    chk("in_ready", DW'(in_ready), DW'(k >= ready_from));
    @(posedge clk);
    if (acc) held = d;
    h_acc[k % R] = acc;
    h_last[k % R] = acc && l;
    h_hold[k % R] = held;
    if (acc) begin
      if (beats < 65535) beats++;
      if (l) begin
        ready_from = k + L;
        in_burst = 0;
      end else begin
        in_burst = 1;
      end
    end
    k++;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 0;
    in_valid = 0; in_last = 0;
    #1;
    chk("rst op_o", op_o, '0);
    chk("rst en_o", DW'(en_o), '0);
    chk("rst val_o", DW'(val_o), '0);
    chk("rst done_o", DW'(done_o), '0);
    chk("rst busy_o", DW'(busy_o), '0);
    chk("rst in_ready", DW'(in_ready), DW'(1));
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  typedef struct {
    logic v, l;
    logic [DW-1:0] d;
    logic [DW-1:0] op;
    logic [L-1:0] en;
    logic rdy, busy, done;
  } vec_t;

  vec_t tbl [5];
  int lowcnt;
  int donepos;

  initial begin
    tbl[0] = '{1, 1, 64'h4400_4200_4000_3C00, 64'h0000_0000_0000_3C00, 4'b0001, 0, 1, 0};
    tbl[1] = '{0, 0, 64'h0, 64'h0000_0000_4000_3C00, 4'b0010, 0, 1, 0};
    tbl[2] = '{0, 0, 64'h0, 64'h0000_4200_4000_3C00, 4'b0100, 0, 1, 0};
    tbl[3] = '{0, 0, 64'h0, 64'h4400_4200_4000_3C00, 4'b1000, 1, 0, 1};
    tbl[4] = '{0, 0, 64'h0, 64'h4400_4200_4000_3C00, 4'b0000, 1, 0, 0};

    model_clear();
    @(posedge clk);
    do_reset();

    for (int t = 0; t < 5; t++) begin
      step(tbl[t].v, tbl[t].l, tbl[t].d);
      chk("tbl op", op_o, tbl[t].op);
      chk("tbl en", DW'(en_o), DW'(tbl[t].en));
      chk("tbl ready", DW'(in_ready), DW'(tbl[t].rdy));
      chk("tbl busy", DW'(busy_o), DW'(tbl[t].busy));
      chk("tbl done", DW'(done_o), DW'(tbl[t].done));
    end

    // Five-beat burst: DRAIN of 3 cycles, done with lane 3 at 0505.
    for (int b = 1; b <= 5; b++)
      step(1, b == 5, {L{16'(b * 16'h0101)}});
    lowcnt = 0; donepos = 0;
    for (int c = 0; c < 6; c++) begin
      if (!in_ready) lowcnt++;
      if (done_o) begin
        donepos++;
        chk("burst done lane3", DW'(op_o[3*W +: W]), DW'(16'h0505));
      end
      step(0, 0, '0);
    end
    chk("burst drain cycles", DW'(lowcnt), DW'(3));
    chk("burst done count", DW'(donepos), DW'(1));

    // Bubble between two beats, then close the burst.
    step(1, 0, 64'h1111_2222_3333_4444);
    step(0, 0, 64'hDEAD_DEAD_DEAD_DEAD);
    step(1, 1, 64'h5555_6666_7777_8888);
    // Backpressure: a waiting beat held through DRAIN.
    for (int c = 0; c < 6; c++) step(1, 1, 64'hABCD_0123_4567_89AB);
    repeat (6) step(0, 0, '0);

    // Reset two cycles into a 4-beat burst.
    step(1, 0, 64'h0001_0002_0003_0004);
    step(1, 0, 64'h0005_0006_0007_0008);
    do_reset();
    chk("post-reset ready", DW'(in_ready), DW'(1));
    repeat (6) step(0, 0, '0);

    // Random traffic.
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
           {$urandom, $urandom});

`ifdef FP_SKEW_STATS_EN
    for (int c = 0; c < 70000; c++)
      step(1, 0, {$urandom, $urandom});
    chk("stats sat", DW'(beat_cnt_o), DW'(16'hFFFF));
    step(1, 0, '0);
    do_reset();
    chk("stats reset", DW'(beat_cnt_o), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
